// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: load funct3 encodings and FSM states.
package writeback_stage_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_type_t;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/load_extender.sv
// Aligns a raw data-memory word by byte offset and sign/zero-extends per load type.
// Purely combinational; flags unknown funct3 and misaligned half/word loads.
module load_extender
    import writeback_stage_pkg::*;
(
    input  logic [31:0] loadData,
    input  logic [2:0]  loadType,
    input  logic [1:0]  offset,
    output logic [31:0] extended,
    output logic        fault
);

    logic [31:0] shifted;

    assign shifted = loadData >> {offset, 3'b000};

    always_comb begin
        extended = shifted;
        fault    = 1'b0;
        case (loadType)
            LB:  extended = {{24{shifted[7]}}, shifted[7:0]};
            LH: begin
                extended = {{16{shifted[15]}}, shifted[15:0]};
                fault    = offset[0];
            end
            LW:  fault = (offset != 2'b00);
            LBU: extended = {24'h0, shifted[7:0]};
            LHU: begin
                extended = {16'h0, shifted[15:0]};
                fault    = offset[0];
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage driving the register-file write port and retire counter.
// Non-loads write 1 cycle after transfer; loads 1 cycle after loadDataValid; memReady=0 while a load is outstanding.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int COUNT_WIDTH = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   memValid,
    output logic                   memReady,
    input  logic                   memDestEnable,
    input  logic [4:0]             memDestAddress,
    input  logic [31:0]            memResult,
    input  logic                   memIsLoad,
    input  logic [2:0]             memLoadType,
    input  logic [1:0]             memByteOffset,
    input  logic                   loadDataValid,
    input  logic [31:0]            loadData,
    output logic                   destinationEnable,
    output logic [4:0]             writeAddress,
    output logic [31:0]            writeData,
    output logic                   retireValid,
    output logic                   loadFault,
    output logic [COUNT_WIDTH-1:0] instretCount
);

    wb_state_t   state;
    logic        pendDestEnable;
    logic [4:0]  pendDestAddress;
    logic [2:0]  pendLoadType;
    logic [1:0]  pendOffset;
    logic [31:0] loadValue;
    logic        loadIllegal;

    load_extender extender (
        .loadData (loadData),
        .loadType (pendLoadType),
        .offset   (pendOffset),
        .extended (loadValue),
        .fault    (loadIllegal)
    );

    assign memReady = (state == IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            destinationEnable <= 1'b0;
            writeAddress      <= '0;
            writeData         <= '0;
            retireValid       <= 1'b0;
            loadFault         <= 1'b0;
            instretCount      <= '0;
            pendDestEnable    <= 1'b0;
            pendDestAddress   <= '0;
            pendLoadType      <= '0;
            pendOffset        <= '0;
        end else begin
            destinationEnable <= 1'b0;
            retireValid       <= 1'b0;
            loadFault         <= 1'b0;
            case (state)
                IDLE: begin
                    if (memValid) begin
                        if (memIsLoad) begin
                            pendDestEnable  <= memDestEnable;
                            pendDestAddress <= memDestAddress;
                            pendLoadType    <= memLoadType;
                            pendOffset      <= memByteOffset;
                            state           <= WAIT_LOAD;
                        end else begin
                            retireValid  <= 1'b1;
                            instretCount <= instretCount + 1'b1;
                            // x0 still retires but never strobes the register file
                            if (memDestEnable && (memDestAddress != 5'd0)) begin
                                destinationEnable <= 1'b1;
                                writeAddress      <= memDestAddress;
                                writeData         <= memResult;
                            end
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (loadDataValid) begin
                        state <= IDLE;
                        if (loadIllegal) begin
                            loadFault <= 1'b1;
                        end else begin
                            retireValid  <= 1'b1;
                            instretCount <= instretCount + 1'b1;
                            if (pendDestEnable && (pendDestAddress != 5'd0)) begin
                                destinationEnable <= 1'b1;
                                writeAddress      <= pendDestAddress;
                                writeData         <= loadValue;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage; sits directly upstream of the register file and drives its write port (destinationEnable, writeAddress, writeData).
- Accepts one retiring instruction at a time from the memory stage.
- For loads, waits for the data-memory response, then aligns and sign- or zero-extends the returned word.
- Counts retired instructions (instret) and flags malformed loads.

Parameters:
- COUNT_WIDTH, 64, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- memValid  in  1  memory stage presents an instruction
- memReady  out  1  stage can accept; transfer when memValid && memReady
- memDestEnable  in  1  instruction writes rd
- memDestAddress  in  5  rd index
- memResult  in  32  non-load result (ALU or link value, already selected)
- memIsLoad  in  1  instruction is a load
- memLoadType  in  3  load funct3
- memByteOffset  in  2  address[1:0] of the load
- loadDataValid  in  1  data memory returns loadData this cycle
- loadData  in  32  raw aligned word from data memory
- destinationEnable  out  1  register-file write strobe
- writeAddress  out  5  register-file write index
- writeData  out  32  register-file write value
- retireValid  out  1  one-cycle pulse per retired instruction
- loadFault  out  1  one-cycle pulse on an illegal or misaligned load
- instretCount  out  COUNT_WIDTH  retired-instruction count

Behaviour:
- Reset (synchronous, active-high)
  - All outputs go to 0: destinationEnable, writeAddress, writeData, retireValid, loadFault, instretCount.
  - State goes to IDLE.
  - Any pending load is dropped; a loadDataValid arriving after reset is ignored.
- States: IDLE, WAIT_LOAD.
- memReady
  - 1 in IDLE, 0 in WAIT_LOAD.
  - Combinational from state only; never depends on memValid.
- IDLE, transfer with memIsLoad=0
  - Next cycle: retireValid=1.
  - destinationEnable = memDestEnable && (memDestAddress != 0).
  - writeAddress = memDestAddress; writeData = memResult.
  - State stays IDLE, so back-to-back non-loads sustain one instruction per cycle.
- IDLE, transfer with memIsLoad=1
  - Latch dest enable, dest address, load type and offset.
  - Move to WAIT_LOAD; no output pulse.
- WAIT_LOAD
  - Waits indefinitely with memReady=0.
  - loadDataValid is sampled only in WAIT_LOAD; it is ignored in IDLE, including the acceptance cycle.
  - On loadDataValid: return to IDLE at the same edge that registers the write outputs.
  - Load-to-write latency is 1 cycle after loadDataValid.
  - memReady returns to 1 in that output cycle.
- Extraction
  - shifted = loadData >> (8 * offset).
  - LB (000): sign-extend shifted[7:0].
  - LH (001): sign-extend shifted[15:0].
  - LW (010): full word.
  - LBU (100): zero-extend shifted[7:0].
  - LHU (101): zero-extend shifted[15:0].
- Faults
  - Covered cases: funct3 011/110/111; LH/LHU with odd offset; LW with offset != 0.
  - Response: loadFault=1 for one cycle, destinationEnable=0, retireValid=0, instretCount unchanged, state returns to IDLE.
- Pulse outputs
  - destinationEnable, retireValid and loadFault are each 1 for exactly one cycle per event, otherwise 0.
  - writeAddress and writeData hold their last values when destinationEnable=0.
- x0 handling
  - Writes to rd=0 never assert destinationEnable, but the instruction still retires.
- instretCount
  - Increments by 1 on every retireValid cycle.
  - Wraps modulo 2^COUNT_WIDTH.
- Reset in WAIT_LOAD: the load is abandoned, nothing is written or retired, and the stage is ready the next cycle.

Decomposition:
- Package pack holds:
  - typedef enum logic [2:0] load_type_t (LB, LH, LW, LBU, LHU);
  - typedef enum logic wb_state_t (IDLE, WAIT_LOAD).
- One combinational sub-module, load_extender.
  - Inputs: loadData, load type, offset.
  - Outputs: extended value and a fault flag.
  - Instantiated once.

Test Plan:
- Non-load rd=5, result 0x1234_5678 -> next cycle destinationEnable=1, writeAddress=5, writeData=0x12345678, retireValid=1, instretCount=1.
- LB offset=3, loadData=0x80FF_FF00, loadDataValid after 3 wait cycles -> memReady=0 for 4 cycles, then writeData=0xFFFF_FF80 one cycle after loadDataValid.
- LHU offset=2, loadData=0xBEEF_0000 -> writeData=0x0000_BEEF; LH with the same data -> 0xFFFF_BEEF.
- LW offset=1 -> loadFault pulse, destinationEnable=0, retireValid=0, instretCount unchanged; the next non-load is accepted the following cycle.
- Non-load rd=0 -> destinationEnable=0, retireValid=1.
- Reset asserted in WAIT_LOAD, then loadDataValid=1 -> no write, counter=0, memReady=1 after reset.
- instretCount preloaded near 2^64-1 (or bench with COUNT_WIDTH=4) -> wraps to 0 on the next retire.
